// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one byte-masked, word-organised memory
// between the core (port 0) and the DMA/program loader (port 1). Each granted
// access runs IDLE -> ACCESS -> RESP, or IDLE -> RESP when the mask/address pair
// is illegal, and ends with a one-cycle done pulse to the owner.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p1_req,
    input  logic              p0_we,
    input  logic              p1_we,
    input  logic [3:0]        p0_mask,
    input  logic [3:0]        p1_mask,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p0_wdata,
    input  logic [31:0]       p1_wdata,
    output logic              p0_done,
    output logic              p1_done,
    output logic              p0_err,
    output logic              p1_err,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              mem_we,
    output logic [3:0]        mem_mask,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              owner;
    logic              last_grant;
    logic              err_q;
    logic [3:0]        cnt;
    logic [31:0]       rdata_q;
    logic              any_req;
    logic              grant;
    logic              grant_legal;
    logic              last_cycle;
    logic              own_we;
    logic [3:0]        own_mask;
    logic [ADDR_W-1:0] own_addr;
    logic [31:0]       own_wdata;

    // Full words, aligned halves and single bytes whose mask sits on the lane
    // selected by the low address bits are the only shapes the memory accepts.
    function automatic logic legal_access(input logic [3:0] mask, input logic [1:0] lane);
        logic ok;
        ok = 1'b0;
        case (mask)
            4'b1111, 4'b0011: ok = (lane == 2'd0);
            4'b1100:          ok = (lane == 2'd2);
            default:          ok = (mask == (4'b0001 << lane));
        endcase
        return ok;
    endfunction

    assign any_req     = p0_req | p1_req;
    // A lone requester wins; with both requesting, the port that lost last time wins.
    assign grant       = (p0_req && p1_req) ? ~last_grant : p1_req;
    assign grant_legal = grant ? legal_access(p1_mask, p1_addr[1:0])
                               : legal_access(p0_mask, p0_addr[1:0]);
    assign last_cycle  = (cnt == LAST_CNT);

    // Memory fields follow the owner's live inputs, which are held stable until done.
    assign own_we    = owner ? p1_we    : p0_we;
    assign own_mask  = owner ? p1_mask  : p0_mask;
    assign own_addr  = owner ? p1_addr  : p0_addr;
    assign own_wdata = owner ? p1_wdata : p0_wdata;
    assign rdata     = rdata_q;

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = grant_legal ? ACCESS : RESP;
            ACCESS:  if (last_cycle) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Grant bookkeeping, wait-state counter and read capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            err_q      <= 1'b0;
            cnt        <= 4'd0;
            rdata_q    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner      <= grant;
                        last_grant <= grant;
                        err_q      <= ~grant_legal;
                        cnt        <= 4'd0;
                    end
                end
                ACCESS: begin
                    if (last_cycle) begin
                        if (!own_we) rdata_q <= mem_rdata;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode: memory bus only in ACCESS, strobe only in its final cycle,
    // done/err only to the owner in RESP.
    always_comb begin
        busy      = (state != IDLE);
        mem_we    = 1'b0;
        mem_mask  = 4'd0;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        p0_done   = 1'b0;
        p1_done   = 1'b0;
        p0_err    = 1'b0;
        p1_err    = 1'b0;
        case (state)
            ACCESS: begin
                mem_mask  = own_mask;
                mem_addr  = own_addr;
                mem_wdata = own_wdata;
                mem_we    = own_we && last_cycle;
            end
            RESP: begin
                p0_done = ~owner;
                p1_done = owner;
                p0_err  = ~owner && err_q;
                p1_err  = owner && err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (no wait states / three wait states)
// share one set of port inputs, each with its own behavioural memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        p0_req, p1_req, p0_we, p1_we;
    logic [3:0]  p0_mask, p1_mask;
    logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;

    logic        a_p0_done, a_p1_done, a_p0_err, a_p1_err, a_busy, a_mem_we;
    logic [31:0] a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [3:0]  a_mem_mask;
    logic        b_p0_done, b_p1_done, b_p0_err, b_p1_err, b_busy, b_mem_we;
    logic [31:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [3:0]  b_mem_mask;

    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:63];
    logic        poke_en = 1'b0;
    logic        poke_sel = 1'b0;
    logic [5:0]  poke_idx = 6'd0;
    logic [31:0] poke_val = 32'd0;

    int          cyc = 0;
    int          a_we_cnt = 0;
    int          b_we_cnt = 0;
    int          b_done_cnt = 0;
    logic [31:0] a_we_addr = 32'd0;
    logic [3:0]  a_we_mask = 4'd0;
    logic [31:0] a_we_wdata = 32'd0;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic        port;
        logic        err;
        logic        chk_rd;
        logic [31:0] rd;
        int          lat;
    } exp_t;
    exp_t sb[$];

    mem_arbiter #(.ADDR_W(32), .WAIT_CYCLES(0)) dut_a (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p1_req(p1_req), .p0_we(p0_we), .p1_we(p1_we),
        .p0_mask(p0_mask), .p1_mask(p1_mask), .p0_addr(p0_addr), .p1_addr(p1_addr),
        .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
        .p0_done(a_p0_done), .p1_done(a_p1_done), .p0_err(a_p0_err), .p1_err(a_p1_err),
        .rdata(a_rdata), .busy(a_busy), .mem_we(a_mem_we), .mem_mask(a_mem_mask),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    mem_arbiter #(.ADDR_W(32), .WAIT_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p1_req(p1_req), .p0_we(p0_we), .p1_we(p1_we),
        .p0_mask(p0_mask), .p1_mask(p1_mask), .p0_addr(p0_addr), .p1_addr(p1_addr),
        .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
        .p0_done(b_p0_done), .p1_done(b_p1_done), .p0_err(b_p0_err), .p1_err(b_p1_err),
        .rdata(b_rdata), .busy(b_busy), .mem_we(b_mem_we), .mem_mask(b_mem_mask),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [3:0] m, input logic [1:0] a);
        logic [31:0] sh;
        logic [31:0] r;
        sh = wd << {a, 3'b000};
        r  = old;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = sh[8*i +: 8];
        return r;
    endfunction

    assign a_mem_rdata = mem_a[a_mem_addr[7:2]] >> {a_mem_addr[1:0], 3'b000};
    assign b_mem_rdata = mem_b[b_mem_addr[7:2]] >> {b_mem_addr[1:0], 3'b000};

    // Memory models: bench preload port has priority, otherwise byte-lane writes.
    always @(posedge clk) begin
        if (poke_en && !poke_sel) mem_a[poke_idx] <= poke_val;
        else if (a_mem_we) mem_a[a_mem_addr[7:2]] <= merge_word(mem_a[a_mem_addr[7:2]], a_mem_wdata, a_mem_mask, a_mem_addr[1:0]);
        if (poke_en && poke_sel) mem_b[poke_idx] <= poke_val;
        else if (b_mem_we) mem_b[b_mem_addr[7:2]] <= merge_word(mem_b[b_mem_addr[7:2]], b_mem_wdata, b_mem_mask, b_mem_addr[1:0]);
    end

    // Cycle counter and strobe/done monitors.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (a_mem_we) begin
            a_we_cnt   <= a_we_cnt + 1;
            a_we_addr  <= a_mem_addr;
            a_we_mask  <= a_mem_mask;
            a_we_wdata <= a_mem_wdata;
        end
        if (b_mem_we) b_we_cnt <= b_we_cnt + 1;
        if (b_p0_done || b_p1_done) b_done_cnt <= b_done_cnt + 1;
    end

    task automatic clear_inputs();
        p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0;
        p0_mask = 0; p1_mask = 0; p0_addr = 0; p1_addr = 0; p0_wdata = 0; p1_wdata = 0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic poke(input logic sel, input logic [5:0] idx, input logic [31:0] val);
        poke_sel = sel; poke_idx = idx; poke_val = val; poke_en = 1'b1;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic set_port(input logic p, input logic we, input logic [3:0] mask,
                            input logic [31:0] addr, input logic [31:0] wdata);
        if (p) begin p1_req = 1; p1_we = we; p1_mask = mask; p1_addr = addr; p1_wdata = wdata; end
        else   begin p0_req = 1; p0_we = we; p0_mask = mask; p0_addr = addr; p0_wdata = wdata; end
    endtask

    // Waits (bounded) for a done pulse on instance a (sel=0) or b (sel=1).
    task automatic wait_done(input logic sel, input int budget, output logic got, output logic port,
                             output logic err, output logic both, output logic [31:0] rd, output int at);
        logic d0, d1;
        got = 0; port = 0; err = 0; both = 0; rd = 0; at = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            d0 = sel ? b_p0_done : a_p0_done;
            d1 = sel ? b_p1_done : a_p1_done;
            if (d0 || d1) begin
                got  = 1;
                port = d1;
                both = d0 && d1;
                err  = d1 ? (sel ? b_p1_err : a_p1_err) : (sel ? b_p0_err : a_p0_err);
                rd   = sel ? b_rdata : a_rdata;
                at   = cyc;
            end
        end
    endtask

    task automatic test_reset();
        int wc, dc;
        clear_inputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", a_busy); end
        n_cmp++; if ({a_p0_done, a_p1_done, a_p0_err, a_p1_err} !== 4'b0) begin n_fail++;
            $display("FAIL rst_done_err: got %b want 0000", {a_p0_done, a_p1_done, a_p0_err, a_p1_err}); end
        n_cmp++; if (a_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", a_rdata); end
        n_cmp++; if ({a_mem_we, a_mem_mask, a_mem_addr, a_mem_wdata} !== 69'd0) begin n_fail++;
            $display("FAIL rst_membus: got we=%b mask=%b addr=%h wdata=%h want all 0", a_mem_we, a_mem_mask, a_mem_addr, a_mem_wdata); end
        poke(1'b1, 6'd4, 32'hA5A5A5A5);
        rst = 1'b1;
        @(negedge clk);
        wc = b_we_cnt; dc = b_done_cnt;
        set_port(1'b0, 1'b1, 4'b1111, 32'h10, 32'h12345678);
        repeat (2) @(negedge clk);
        n_cmp++; if (b_busy !== 1'b1) begin n_fail++; $display("FAIL rst_in_access: busy got %b want 1", b_busy); end
        rst = 1'b0; p0_req = 1'b0;
        #1;
        n_cmp++; if ({b_busy, b_mem_we, b_mem_mask, b_mem_addr, b_mem_wdata} !== 70'd0) begin n_fail++;
            $display("FAIL rst_async_clear: got busy=%b we=%b mask=%b addr=%h want all 0", b_busy, b_mem_we, b_mem_mask, b_mem_addr); end
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++; if (b_we_cnt !== wc) begin n_fail++; $display("FAIL rst_no_strobe: got %0d strobes want %0d", b_we_cnt, wc); end
        n_cmp++; if (b_done_cnt !== dc) begin n_fail++; $display("FAIL rst_no_done: got %0d dones want %0d", b_done_cnt, dc); end
        n_cmp++; if (mem_b[4] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL rst_mem_kept: got %h want a5a5a5a5", mem_b[4]); end
        n_cmp++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_after: busy got %b want 0", b_busy); end
    endtask

    task automatic test_read();
        int c0, at; logic got, port, err, both; logic [31:0] rd; exp_t e;
        poke(1'b0, 6'd2, 32'hFFAABBCC);
        apply_reset();
        c0 = cyc;
        set_port(1'b0, 1'b0, 4'b1111, 32'h8, 32'h0);
        sb.push_back('{port: 1'b0, err: 1'b0, chk_rd: 1'b1, rd: 32'hFFAABBCC, lat: 2});
        wait_done(1'b0, 8, got, port, err, both, rd, at);
        p0_req = 1'b0;
        e = sb.pop_front();
        n_cmp++; if (got !== 1'b1) begin n_fail++; $display("FAIL read_timeout: got no done want done"); end
        n_cmp++; if (port !== e.port) begin n_fail++; $display("FAIL read_port: got %b want %b", port, e.port); end
        n_cmp++; if (err !== e.err) begin n_fail++; $display("FAIL read_err: got %b want %b", err, e.err); end
        n_cmp++; if (rd !== e.rd) begin n_fail++; $display("FAIL read_rdata: got %h want %h", rd, e.rd); end
        n_cmp++; if (at - c0 !== e.lat) begin n_fail++; $display("FAIL read_latency: got %0d want %0d", at - c0, e.lat); end
        @(negedge clk);
    endtask

    task automatic test_write();
        int c0, at, wc; logic got, port, err, both; logic [31:0] rd; exp_t e;
        poke(1'b0, 6'd5, 32'h11223344);
        apply_reset();
        wc = a_we_cnt;
        c0 = cyc;
        set_port(1'b1, 1'b1, 4'b0010, 32'h15, 32'hCC);
        sb.push_back('{port: 1'b1, err: 1'b0, chk_rd: 1'b0, rd: 32'h0, lat: 2});
        wait_done(1'b0, 8, got, port, err, both, rd, at);
        p1_req = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        n_cmp++; if (got !== 1'b1) begin n_fail++; $display("FAIL write_timeout: got no done want done"); end
        n_cmp++; if (port !== e.port) begin n_fail++; $display("FAIL write_port: got %b want %b", port, e.port); end
        n_cmp++; if (err !== e.err) begin n_fail++; $display("FAIL write_err: got %b want %b", err, e.err); end
        n_cmp++; if (at - c0 !== e.lat) begin n_fail++; $display("FAIL write_latency: got %0d want %0d", at - c0, e.lat); end
        n_cmp++; if (a_we_cnt - wc !== 1) begin n_fail++; $display("FAIL write_strobes: got %0d want 1", a_we_cnt - wc); end
        n_cmp++; if ({a_we_addr, a_we_mask, a_we_wdata} !== {32'h15, 4'b0010, 32'hCC}) begin n_fail++;
            $display("FAIL write_bus: got addr=%h mask=%b wdata=%h want 15/0010/cc", a_we_addr, a_we_mask, a_we_wdata); end
        n_cmp++; if (mem_a[5] !== 32'h1122CC44) begin n_fail++; $display("FAIL write_mem: got %h want 1122cc44", mem_a[5]); end
    endtask

    task automatic test_back_to_back();
        int c0, at, ref_cyc; logic got, port, err, both; logic [31:0] rd; exp_t e;
        poke(1'b0, 6'd0, 32'h0000AAAA);
        poke(1'b0, 6'd1, 32'h0000BBBB);
        apply_reset();
        c0 = cyc;
        set_port(1'b0, 1'b0, 4'b1111, 32'h0, 32'h0);
        set_port(1'b1, 1'b0, 4'b1111, 32'h4, 32'h0);
        sb.push_back('{port: 1'b0, err: 1'b0, chk_rd: 1'b1, rd: 32'h0000AAAA, lat: 2});
        sb.push_back('{port: 1'b1, err: 1'b0, chk_rd: 1'b1, rd: 32'h0000BBBB, lat: 3});
        sb.push_back('{port: 1'b0, err: 1'b0, chk_rd: 1'b1, rd: 32'h0000AAAA, lat: 3});
        sb.push_back('{port: 1'b1, err: 1'b0, chk_rd: 1'b1, rd: 32'h0000BBBB, lat: 3});
        ref_cyc = c0;
        for (int k = 0; k < 4; k++) begin
            wait_done(1'b0, 10, got, port, err, both, rd, at);
            e = sb.pop_front();
            n_cmp++; if (got !== 1'b1) begin n_fail++; $display("FAIL rr_timeout[%0d]: got no done want done", k); end
            n_cmp++; if (both !== 1'b0) begin n_fail++; $display("FAIL rr_overlap[%0d]: got both dones want one", k); end
            n_cmp++; if (port !== e.port) begin n_fail++; $display("FAIL rr_port[%0d]: got %b want %b", k, port, e.port); end
            n_cmp++; if (rd !== e.rd) begin n_fail++; $display("FAIL rr_rdata[%0d]: got %h want %h", k, rd, e.rd); end
            n_cmp++; if (at - ref_cyc !== e.lat) begin n_fail++; $display("FAIL rr_spacing[%0d]: got %0d want %0d", k, at - ref_cyc, e.lat); end
            ref_cyc = at;
        end
        p0_req = 1'b0; p1_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_illegal();
        int c0, at, wc, busy_n; logic seen, err; exp_t e;
        apply_reset();
        wc = a_we_cnt;
        c0 = cyc;
        set_port(1'b0, 1'b1, 4'b1111, 32'h2, 32'hDEADBEEF);
        sb.push_back('{port: 1'b0, err: 1'b1, chk_rd: 1'b0, rd: 32'h0, lat: 1});
        busy_n = 0; seen = 0; err = 0; at = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (a_busy) busy_n++;
            if (a_p0_done && !seen) begin
                seen = 1; at = cyc; err = a_p0_err; p0_req = 1'b0;
            end
        end
        e = sb.pop_front();
        n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("FAIL illegal_timeout: got no done want done"); end
        n_cmp++; if (err !== e.err) begin n_fail++; $display("FAIL illegal_err: got %b want %b", err, e.err); end
        n_cmp++; if (at - c0 !== e.lat) begin n_fail++; $display("FAIL illegal_latency: got %0d want %0d", at - c0, e.lat); end
        n_cmp++; if (busy_n !== 1) begin n_fail++; $display("FAIL illegal_busy: got %0d cycles want 1", busy_n); end
        n_cmp++; if (a_we_cnt !== wc) begin n_fail++; $display("FAIL illegal_strobe: got %0d strobes want %0d", a_we_cnt, wc); end
    endtask

    task automatic test_wait_states();
        int c0, at, ref_cyc; logic got, port, err, both; logic [31:0] rd; exp_t e;
        poke(1'b1, 6'd3, 32'h5A5A0001);
        poke(1'b1, 6'd8, 32'h770000EE);
        apply_reset();
        c0 = cyc;
        set_port(1'b1, 1'b0, 4'b1111, 32'hC, 32'h0);
        sb.push_back('{port: 1'b1, err: 1'b0, chk_rd: 1'b1, rd: 32'h5A5A0001, lat: 5});
        sb.push_back('{port: 1'b0, err: 1'b0, chk_rd: 1'b1, rd: 32'h770000EE, lat: 6});
        repeat (2) @(negedge clk);
        set_port(1'b0, 1'b0, 4'b0001, 32'h20, 32'h0);
        ref_cyc = c0;
        for (int k = 0; k < 2; k++) begin
            wait_done(1'b1, 12, got, port, err, both, rd, at);
            if (k == 0) p1_req = 1'b0; else p0_req = 1'b0;
            e = sb.pop_front();
            n_cmp++; if (got !== 1'b1) begin n_fail++; $display("FAIL wait_timeout[%0d]: got no done want done", k); end
            n_cmp++; if (port !== e.port) begin n_fail++; $display("FAIL wait_port[%0d]: got %b want %b", k, port, e.port); end
            n_cmp++; if (err !== e.err) begin n_fail++; $display("FAIL wait_err[%0d]: got %b want %b", k, err, e.err); end
            n_cmp++; if (rd !== e.rd) begin n_fail++; $display("FAIL wait_rdata[%0d]: got %h want %h", k, rd, e.rd); end
            n_cmp++; if (at - ref_cyc !== e.lat) begin n_fail++; $display("FAIL wait_latency[%0d]: got %0d want %0d", k, at - ref_cyc, e.lat); end
            ref_cyc = at;
        end
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_illegal();
        test_wait_states();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
